// File: rtl/bus_arbiter.sv
// Two-requester (fetch/data) arbiter for a single-port memory with fixed data priority.
// Optional grant timeout is compiled in with the ARB_TIMEOUT_EN macro.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ibus_req_i,
    input  logic [31:0] ibus_addr_i,
    output logic [31:0] ibus_rdata_o,
    output logic        ibus_ack_o,
    input  logic        dbus_req_i,
    input  logic        dbus_we_i,
    input  logic [3:0]  dbus_sel_i,
    input  logic [31:0] dbus_addr_i,
    input  logic [31:0] dbus_wdata_i,
    output logic [31:0] dbus_rdata_o,
    output logic        dbus_ack_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [5:0]  stall_o,
    output logic        err_o
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_e;

    state_e state_q, state_d;
    logic   gnt_req;
    logic   tmo;

    function automatic state_e pick(input logic dreq, input logic ireq);
        if (dreq)      return DGRANT;
        else if (ireq) return IGRANT;
        else           return IDLE;
    endfunction

    always_comb begin
        gnt_req = 1'b0;
        if (state_q == DGRANT)      gnt_req = dbus_req_i;
        else if (state_q == IGRANT) gnt_req = ibus_req_i;
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] cnt_q, cnt_d;

    // cnt_q counts granted cycles without ack; reaching the limit means the
    // previous cycle held TIMEOUT_CYCLES-1, so this cycle is the forced end.
    assign tmo = (state_q != IDLE) && gnt_req && (cnt_q == TMO_LIMIT);

    always_comb begin
        cnt_d = 8'd0;
        if (state_q != IDLE && gnt_req && !mem_ack_i && !tmo)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else     cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;

    if (TIMEOUT_CYCLES > 255) begin : g_tmo_wide
    end
`endif

    // Completion (ack) wins over an abort; a timeout always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = pick(dbus_req_i, ibus_req_i);
            IGRANT,
            DGRANT: begin
                if (tmo)            state_d = IDLE;
                else if (mem_ack_i) state_d = pick(dbus_req_i, ibus_req_i);
                else if (!gnt_req)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        mem_ce_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_sel_o    = 4'h0;
        mem_addr_o   = 32'h0;
        mem_wdata_o  = 32'h0;
        ibus_ack_o   = 1'b0;
        ibus_rdata_o = 32'h0;
        dbus_ack_o   = 1'b0;
        dbus_rdata_o = 32'h0;
        err_o        = 1'b0;
        stall_o      = 6'b000000;
        if (!rst) begin
            case (state_q)
                IGRANT: begin
                    mem_ce_o     = ibus_req_i && !tmo;
                    mem_sel_o    = 4'hF;
                    mem_addr_o   = ibus_addr_i;
                    ibus_ack_o   = tmo || mem_ack_i;
                    ibus_rdata_o = tmo ? 32'h0 : mem_rdata_i;
                end
                DGRANT: begin
                    mem_ce_o     = dbus_req_i && !tmo;
                    mem_we_o     = dbus_we_i;
                    mem_sel_o    = dbus_sel_i;
                    mem_addr_o   = dbus_addr_i;
                    mem_wdata_o  = dbus_wdata_i;
                    dbus_ack_o   = tmo || mem_ack_i;
                    dbus_rdata_o = tmo ? 32'h0 : mem_rdata_i;
                end
                default: ;
            endcase
            err_o = tmo;
            if (dbus_req_i && !dbus_ack_o)      stall_o = 6'b011111;
            else if (ibus_req_i && !ibus_ack_o) stall_o = 6'b000111;
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of granted cycles without mem_ack_i before forced termination; the parameter is used only when ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ibus_req_i (input, 1), ibus_addr_i (input, 32), ibus_rdata_o (output, 32) and ibus_ack_o (output, 1), together forming the instruction-fetch requester port.
REQ-005 SHALL have dbus_req_i (input, 1), dbus_we_i (input, 1), dbus_sel_i (input, 4), dbus_addr_i (input, 32), dbus_wdata_i (input, 32), dbus_rdata_o (output, 32) and dbus_ack_o (output, 1), together forming the data (MEM stage) requester port.
REQ-006 SHALL have mem_ce_o (output, 1), mem_we_o (output, 1), mem_sel_o (output, 4), mem_addr_o (output, 32), mem_wdata_o (output, 32), mem_rdata_i (input, 32) and mem_ack_i (input, 1), together forming the shared single-port memory.
REQ-007 SHALL have stall_o (output, 6), the pipeline stall vector; bit0 is pc, bit1 is if, bit2 is id, bit3 is ex, bit4 is mem and bit5 is wb.
REQ-008 SHALL have err_o (output, 1), a one-cycle pulse that signals a timeout abort.

Function
REQ-009 SHALL implement a state machine with the states IDLE, IGRANT and DGRANT; the state and all outputs are driven from the registered state and the current inputs.
REQ-010 In IDLE, on a clock edge, dbus_req_i=1 SHALL select DGRANT; otherwise ibus_req_i=1 SHALL select IGRANT; otherwise the machine stays in IDLE. Data has fixed priority.
REQ-011 In xGRANT, the mem_* outputs SHALL combinationally mirror the granted port's inputs. Ibus grant forces mem_we_o=0 and mem_sel_o=4'hF. mem_ce_o equals the granted req input.
REQ-012 In xGRANT, x_ack_o SHALL equal mem_ack_i and x_rdata_o SHALL equal mem_rdata_i. The non-granted ack SHALL be 0 and the non-granted rdata SHALL be 32'h0.
REQ-013 There SHALL be no preemption: a grant holds until mem_ack_i=1, or until the granted req drops (abort), or until timeout.
REQ-014 On the ack cycle, the next state SHALL be chosen by the REQ-010 priority, so back-to-back grants have no idle cycle. A requester that is acked and still requesting counts as a new request.
REQ-015 If the granted req drops without ack, the arbiter SHALL return to IDLE next cycle with no ack issued.
REQ-016 Minimum latency from req to ack SHALL be 1 cycle (req at edge N, grant at N+1, ack in that cycle if memory is zero-wait).
REQ-017 stall_o SHALL be 6'b011111 when dbus_req_i=1 and dbus_ack_o=0.
REQ-018 Otherwise, stall_o SHALL be 6'b000111 when ibus_req_i=1 and ibus_ack_o=0.
REQ-019 In all other cases, stall_o SHALL be 6'b000000.
REQ-020 Simultaneous requests in IDLE SHALL grant dbus first. Ibus SHALL be granted on the cycle after the dbus ack, unless dbus requests again.
REQ-021 Address, data and sel values SHALL pass through unmodified at the full 32/32/4-bit width.

Reset
REQ-022 rst=1 SHALL immediately force IDLE and clear the timeout counter.
REQ-023 rst=1 SHALL immediately force mem_ce_o, mem_we_o, both acks and err_o to 0, mem_sel_o, mem_addr_o, mem_wdata_o and both rdata outputs to 0, and stall_o to 6'h00.
REQ-024 Reset during a grant SHALL abort the transfer with no ack issued.

Configuration
REQ-025 With macro ARB_TIMEOUT_EN defined, an 8-bit cycle counter SHALL clear on each grant entry and increment on each granted cycle without mem_ack_i.
REQ-026 With ARB_TIMEOUT_EN defined, once the counter reaches TIMEOUT_CYCLES-1 without ack, the arbiter SHALL, in the next cycle, drive the granted x_ack_o=1 with x_rdata_o=32'h0 and err_o=1 for one cycle, drive mem_ce_o=0, and then enter IDLE.
REQ-027 With ARB_TIMEOUT_EN undefined, the counter SHALL be absent, grants SHALL wait indefinitely for mem_ack_i, and err_o SHALL be tied to 0.

Verification
REQ-028 Fetch only, zero-wait memory: ibus_req_i=1, ibus_addr_i=32'h100, mem_rdata_i=32'h3401_0020, and mem_ack_i=1 when ce=1 -> ibus_ack_o=1 one cycle after req, ibus_rdata_o=32'h3401_0020, stall_o=6'b000111 in the request cycle only.
REQ-029 Simultaneous requests: ibus and dbus both request; dbus is a write with addr 32'h200, wdata 32'hDEAD_BEEF and sel 4'hF -> the mem port shows the write first with mem_we_o=1 and stall_o=6'b011111, then the ibus grant follows immediately after the dbus ack.
REQ-030 Wait states: a dbus read where the memory acks after 3 cycles -> stall_o=6'b011111 for 4 cycles and dbus_ack_o=1 exactly once.
REQ-031 Abort and reset: dropping ibus_req_i mid-grant -> IDLE with no ack. Asserting rst mid-DGRANT -> mem_ce_o=0 in the same cycle and all outputs at reset values.
REQ-032 Timeout with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, memory never acks: dbus read -> dbus_ack_o=1, dbus_rdata_o=0 and err_o=1 on the 5th granted cycle, then IDLE. Without ARB_TIMEOUT_EN, the same stimulus -> the stall is held for 100 cycles with no ack.
